// File: rtl/core_clock_pkg.sv
// Shared types and defaults for the core clock-gating controller.
// Channel FSM encoding is fixed so status can be decoded from the state bits.
package core_clock_pkg;

   localparam int unsigned DefaultChannels = 4;
   localparam int unsigned DefaultHoldW    = 4;

   typedef enum logic [1:0] {
      StOff  = 2'd0,
      StWake = 2'd1,
      StOn   = 2'd2,
      StHold = 2'd3
   } chan_state_e;

endpackage

// File: rtl/core_clock_chan.sv
// One gated clock domain: OFF/WAKE/ON/HOLD handshake FSM, idle hold-off counter
// and the clock gate cell it drives.
module core_clock_chan
   import core_clock_pkg::*;
#(
   parameter int unsigned HOLD_W = DefaultHoldW
) (
   input  logic              g_clk,
   input  logic              g_reset,
   input  logic              tst_en,
   input  logic [HOLD_W-1:0] cfg_hold,
   input  logic              req,
   input  logic              force_on,
   output logic              ack,
   output logic              active,
   output logic              is_off,
   output logic              clk_out
);

   chan_state_e       state_q, state_d;
   logic [HOLD_W-1:0] cnt_q, cnt_d;
   logic              r;
   logic              en;
   logic              hold_zero;

   assign r         = req | force_on;
   assign hold_zero = (cfg_hold == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StOff: begin
            if (r) begin
               state_d = StWake;
            end
         end
         StWake: begin
            if (r) begin
               state_d = StOn;
            end else if (hold_zero) begin
               state_d = StOff;
            end else begin
               state_d = StHold;
               cnt_d   = cfg_hold;
            end
         end
         StOn: begin
            if (!r) begin
               if (hold_zero) begin
                  state_d = StOff;
               end else begin
                  state_d = StHold;
                  cnt_d   = cfg_hold;
               end
            end
         end
         StHold: begin
            // Clock never stopped in HOLD, so a new request goes straight back to ON.
            if (r) begin
               state_d = StOn;
               cnt_d   = '0;
            end else if (cnt_q <= HOLD_W'(1)) begin
               state_d = StOff;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - HOLD_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q <= StOff;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Reset forces the gate open so the domain sees reset edges.
   assign en      = (state_q != StOff) | g_reset;
   assign active  = en;
   assign ack     = (state_q == StOn) | (state_q == StHold);
   assign is_off  = (state_q == StOff);

   core_clock_gate u_gate (
      .clk     (g_clk),
      .clk_req (en),
      .tst_en  (tst_en),
      .clk_out (clk_out)
   );

endmodule

// File: rtl/core_clock_gate.sv
// Glitch-free clock gate: enable captured in a low-phase latch, ANDed with the clock.
// Formal builds collapse the latch to a plain AND gate.
module core_clock_gate (
   input  logic clk,
   input  logic clk_req,
   input  logic tst_en,
   output logic clk_out
);

`ifdef CLOCK_GATE_NO_LATCH
   assign clk_out = clk & (clk_req | tst_en);
`else
   logic en_latch;

   // Transparent while clk is low so the enable is stable across the high phase.
   always_latch begin
      if (!clk) begin
         en_latch <= clk_req | tst_en;
      end
   end

   assign clk_out = clk & en_latch;
`endif

endmodule

// File: rtl/core_clock_ctrl.sv
// Multi-channel clock-gating controller: one handshake channel per gated domain
// plus a registered global sleep acknowledge.
module core_clock_ctrl
   import core_clock_pkg::*;
#(
   parameter int unsigned CHANNELS = DefaultChannels,
   parameter int unsigned HOLD_W   = DefaultHoldW
) (
   input  logic                g_clk,
   input  logic                g_reset,
   input  logic                tst_en,
   input  logic [HOLD_W-1:0]   cfg_hold,
   input  logic [CHANNELS-1:0] ch_req,
   input  logic [CHANNELS-1:0] ch_force_on,
   output logic [CHANNELS-1:0] ch_ack,
   output logic [CHANNELS-1:0] ch_active,
   output logic [CHANNELS-1:0] clk_out,
   input  logic                sleep_req,
   output logic                sleep_ack
);

   logic [CHANNELS-1:0] ch_off;
   logic                all_idle;
   logic                sleep_ack_q, sleep_ack_d;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      core_clock_chan #(
         .HOLD_W (HOLD_W)
      ) u_chan (
         .g_clk    (g_clk),
         .g_reset  (g_reset),
         .tst_en   (tst_en),
         .cfg_hold (cfg_hold),
         .req      (ch_req[i]),
         .force_on (ch_force_on[i]),
         .ack      (ch_ack[i]),
         .active   (ch_active[i]),
         .is_off   (ch_off[i]),
         .clk_out  (clk_out[i])
      );
   end

   // A pending request counts as busy so sleep never acks across a wake-up.
   assign all_idle    = (&ch_off) & ~(|(ch_req | ch_force_on));
   assign sleep_ack_d = sleep_req & all_idle;

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         sleep_ack_q <= 1'b0;
      end else begin
         sleep_ack_q <= sleep_ack_d;
      end
   end

   assign sleep_ack = sleep_ack_q;

endmodule

// File: tb/tb_core_clock_ctrl.sv
// Directed, table-driven bench for core_clock_ctrl with clock pulse counting per channel.
module tb_core_clock_ctrl;

   localparam int unsigned Ch = 4;
   localparam int unsigned Hw = 4;

   logic          g_clk = 1'b0;
   logic          g_reset = 1'b1;
   logic          tst_en = 1'b0;
   logic [Hw-1:0] cfg_hold = 4'd3;
   logic [Ch-1:0] ch_req = '0;
   logic [Ch-1:0] ch_force_on = '0;
   logic [Ch-1:0] ch_ack;
   logic [Ch-1:0] ch_active;
   logic [Ch-1:0] clk_out;
   logic          sleep_req = 1'b0;
   logic          sleep_ack;

   core_clock_ctrl #(
      .CHANNELS (Ch),
      .HOLD_W   (Hw)
   ) dut (
      .g_clk       (g_clk),
      .g_reset     (g_reset),
      .tst_en      (tst_en),
      .cfg_hold    (cfg_hold),
      .ch_req      (ch_req),
      .ch_force_on (ch_force_on),
      .ch_ack      (ch_ack),
      .ch_active   (ch_active),
      .clk_out     (clk_out),
      .sleep_req   (sleep_req),
      .sleep_ack   (sleep_ack)
   );

   always #5 g_clk = ~g_clk;

   int unsigned edge_cnt [Ch];
   int unsigned snap [Ch];

   for (genvar g = 0; g < Ch; g++) begin : g_cnt
      initial edge_cnt[g] = 0;
      always @(posedge clk_out[g]) edge_cnt[g] = edge_cnt[g] + 1;
   end

   typedef struct {
      logic       rst;
      logic       tst;
      logic [3:0] hold;
      logic [3:0] req;
      logic [3:0] frc;
      logic       slp;
      logic [3:0] ack;
      logic [3:0] act;
      logic       sleep;
      logic [3:0] clk;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   function automatic void add(logic rst, logic tst, logic [3:0] hold, logic [3:0] req,
                               logic [3:0] frc, logic slp, logic [3:0] ack, logic [3:0] act,
                               logic sleep, logic [3:0] clk);
      vec_t v;
      v.rst = rst; v.tst = tst; v.hold = hold; v.req = req; v.frc = frc; v.slp = slp;
      v.ack = ack; v.act = act; v.sleep = sleep; v.clk = clk;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input int idx, input logic [3:0] got,
                      input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge g_clk);
      #1;
   endtask

   function automatic logic [3:0] pulses();
      logic [3:0] m;
      for (int g = 0; g < Ch; g++) begin
         m[g] = (edge_cnt[g] != snap[g]);
         snap[g] = edge_cnt[g];
      end
      return m;
   endfunction

   initial begin
      for (int g = 0; g < Ch; g++) snap[g] = 0;
      //   rst tst hold req  frc  slp   ack  act  slp clk
      add(1, 0, 3, 4'h0, 4'h0, 0,   4'h0, 4'hF, 0, 4'hF);
      add(1, 0, 3, 4'h0, 4'h0, 0,   4'h0, 4'hF, 0, 4'hF);
      add(0, 0, 3, 4'h0, 4'h0, 0,   4'h0, 4'h0, 0, 4'h0);
      add(0, 0, 3, 4'h1, 4'h0, 0,   4'h0, 4'h1, 0, 4'h0);
      add(0, 0, 3, 4'h1, 4'h0, 0,   4'h1, 4'h1, 0, 4'h1);
      add(0, 0, 3, 4'h1, 4'h0, 0,   4'h1, 4'h1, 0, 4'h1);
      add(0, 0, 3, 4'h0, 4'h0, 0,   4'h1, 4'h1, 0, 4'h1);
      add(0, 0, 3, 4'h0, 4'h0, 0,   4'h1, 4'h1, 0, 4'h1);
      add(0, 0, 3, 4'h0, 4'h0, 0,   4'h1, 4'h1, 0, 4'h1);
      add(0, 0, 3, 4'h0, 4'h0, 0,   4'h0, 4'h0, 0, 4'h1);
      add(0, 0, 3, 4'h0, 4'h0, 0,   4'h0, 4'h0, 0, 4'h0);
      // channel 1 re-raised during HOLD, then cfg_hold=0 drop
      add(0, 0, 4, 4'h2, 4'h0, 0,   4'h0, 4'h2, 0, 4'h0);
      add(0, 0, 4, 4'h2, 4'h0, 0,   4'h2, 4'h2, 0, 4'h2);
      add(0, 0, 4, 4'h0, 4'h0, 0,   4'h2, 4'h2, 0, 4'h2);
      add(0, 0, 4, 4'h0, 4'h0, 0,   4'h2, 4'h2, 0, 4'h2);
      add(0, 0, 4, 4'h2, 4'h0, 0,   4'h2, 4'h2, 0, 4'h2);
      add(0, 0, 4, 4'h2, 4'h0, 0,   4'h2, 4'h2, 0, 4'h2);
      add(0, 0, 0, 4'h0, 4'h0, 0,   4'h0, 4'h0, 0, 4'h2);
      // force-on channel 2 under sleep_req
      add(0, 0, 2, 4'h0, 4'h4, 1,   4'h0, 4'h4, 0, 4'h0);
      add(0, 0, 2, 4'h0, 4'h4, 1,   4'h4, 4'h4, 0, 4'h4);
      add(0, 0, 2, 4'h0, 4'h4, 1,   4'h4, 4'h4, 0, 4'h4);
      add(0, 0, 2, 4'h0, 4'h0, 1,   4'h4, 4'h4, 0, 4'h4);
      add(0, 0, 2, 4'h0, 4'h0, 1,   4'h4, 4'h4, 0, 4'h4);
      add(0, 0, 2, 4'h0, 4'h0, 1,   4'h0, 4'h0, 0, 4'h4);
      add(0, 0, 2, 4'h0, 4'h0, 1,   4'h0, 4'h0, 1, 4'h0);
      add(0, 0, 2, 4'h0, 4'h0, 0,   4'h0, 4'h0, 0, 4'h0);
      add(0, 0, 2, 4'h0, 4'h0, 1,   4'h0, 4'h0, 1, 4'h0);
      // wake-up of channel 3 while asleep
      add(0, 0, 2, 4'h8, 4'h0, 1,   4'h0, 4'h8, 0, 4'h0);
      add(0, 0, 2, 4'h8, 4'h0, 1,   4'h8, 4'h8, 0, 4'h8);
      // reset mid-HOLD
      add(0, 0, 3, 4'h0, 4'h0, 0,   4'h8, 4'h8, 0, 4'h8);
      add(1, 0, 3, 4'h0, 4'h0, 0,   4'h0, 4'hF, 0, 4'hF);
      add(0, 0, 3, 4'h0, 4'h0, 0,   4'h0, 4'h0, 0, 4'h0);
      // WAKE with request gone goes to HOLD; cfg_hold change mid-HOLD ignored
      add(0, 0, 3, 4'h1, 4'h0, 0,   4'h0, 4'h1, 0, 4'h0);
      add(0, 0, 3, 4'h0, 4'h0, 0,   4'h1, 4'h1, 0, 4'h1);
      add(0, 0, 9, 4'h0, 4'h0, 0,   4'h1, 4'h1, 0, 4'h1);
      add(0, 0, 9, 4'h0, 4'h0, 0,   4'h1, 4'h1, 0, 4'h1);
      add(0, 0, 9, 4'h0, 4'h0, 0,   4'h0, 4'h0, 0, 4'h1);
      // reset mid-WAKE
      add(0, 0, 3, 4'h4, 4'h0, 0,   4'h0, 4'h4, 0, 4'h0);
      add(1, 0, 3, 4'h4, 4'h0, 0,   4'h0, 4'hF, 0, 4'hF);
      add(0, 0, 3, 4'h0, 4'h0, 0,   4'h0, 4'h0, 0, 4'h0);
      // scan enable opens every gate without touching the FSMs
      add(0, 1, 3, 4'h0, 4'h0, 0,   4'h0, 4'h0, 0, 4'hF);
      add(0, 1, 3, 4'h0, 4'h0, 0,   4'h0, 4'h0, 0, 4'hF);
      add(0, 0, 3, 4'h0, 4'h0, 0,   4'h0, 4'h0, 0, 4'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         g_reset     = vecs[i].rst;
         tst_en      = vecs[i].tst;
         cfg_hold    = vecs[i].hold;
         ch_req      = vecs[i].req;
         ch_force_on = vecs[i].frc;
         sleep_req   = vecs[i].slp;
         cycle();
         chk("ch_ack", i, ch_ack, vecs[i].ack);
         chk("ch_active", i, ch_active, vecs[i].act);
         chk("sleep_ack", i, {3'b000, sleep_ack}, {3'b000, vecs[i].sleep});
         chk("clk_pulse", i, pulses(), vecs[i].clk);
      end

      // Long force-on: channel 2 must hold ack and block sleep indefinitely.
      cfg_hold    = 4'd2;
      ch_req      = '0;
      ch_force_on = 4'h4;
      sleep_req   = 1'b1;
      cycle();
      cycle();
      for (int k = 0; k < 20; k++) begin
         cycle();
         chk("force_ack", 100 + k, ch_ack, 4'h4);
         chk("force_sleep", 100 + k, {3'b000, sleep_ack}, 4'h0);
      end
      ch_force_on = '0;
      cycle();
      chk("release_hold1", 200, ch_ack, 4'h4);
      cycle();
      chk("release_hold2", 201, ch_ack, 4'h4);
      cycle();
      chk("release_off", 202, ch_ack, 4'h0);
      chk("release_sleep0", 202, {3'b000, sleep_ack}, 4'h0);
      cycle();
      chk("release_sleep1", 203, {3'b000, sleep_ack}, 4'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
